// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: MMIO addresses,
// serializer state encodings and the status-word packing helper.
package uart_tx_buffered_pkg;

  localparam logic [31:0] UART_ADDR        = 32'h1000_0000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned UTX_STATE_W = 2;

  localparam logic [UTX_STATE_W-1:0] UTX_IDLE  = 2'd0;
  localparam logic [UTX_STATE_W-1:0] UTX_START = 2'd1;
  localparam logic [UTX_STATE_W-1:0] UTX_DATA  = 2'd2;
  localparam logic [UTX_STATE_W-1:0] UTX_STOP  = 2'd3;

  typedef struct packed {
    logic       overflow;
    logic       full;
    logic       empty;
    logic [7:0] level;
  } uart_status_t;

  // Status word as software reads it at UART_STATUS_ADDR: {overflow, full, empty, level}.
  function automatic logic [31:0] status_word(input uart_status_t s);
    return 32'(s);
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Store-path / status bundle between the CPU side (master) and the buffered UART (slave).
interface uart_tx_buffered_if #(
  parameter int unsigned ADDR_W = 4
);
  import uart_tx_buffered_pkg::*;

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   clr_overflow;
  logic                   tx;
  logic                   busy;
  logic                   full;
  logic                   empty;
  logic [ADDR_W:0]        level;
  logic                   overflow;

  modport master (
    output wr_en, wr_data, clr_overflow,
    input  tx, busy, full, empty, level, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow,
    output tx, busy, full, empty, level, overflow
  );

endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level; head is shown combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok_c;
  logic              pop_ok_c;
  logic [LVL_W-1:0]  level_next_c;

  // Accept decisions use the pre-edge flags, so a push while full is dropped even if a pop happens.
  always_comb begin
    push_ok_c    = push && !full;
    pop_ok_c     = pop && !empty;
    level_next_c = level;
    case ({push_ok_c, pop_ok_c})
      2'b10:   level_next_c = level + LVL_W'(1);
      2'b01:   level_next_c = level - LVL_W'(1);
      default: level_next_c = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      level <= level_next_c;
      full  <= (level_next_c == LVL_W'(DEPTH));
      empty <= (level_next_c == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: store-path FIFO drained by a serializer onto tx,
// with full/level/sticky-overflow status for software polling.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_buffered_if.slave  bus
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [UTX_STATE_W-1:0] state;
  logic [UTX_STATE_W-1:0] state_next_c;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next_c;
  logic [2:0]             bit_idx;
  logic [2:0]             bit_next_c;
  logic [UART_DATA_W-1:0] shift;
  logic [UART_DATA_W-1:0] shift_next_c;
  logic                   tx_q;
  logic                   tx_next_c;
  logic                   busy_q;
  logic                   busy_next_c;
  logic                   overflow_q;
  logic                   pop_c;
  logic [UART_DATA_W-1:0] head_c;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ADDR_W:0]        fifo_level;

  sync_fifo #(
    .WIDTH  (UART_DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.wr_en),
    .pop   (pop_c),
    .din   (bus.wr_data),
    .dout  (head_c),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign pop_c = (state == UTX_IDLE) && !fifo_empty;

  // Next-state logic; tx and busy are precomputed from the next state so they leave a flop.
  always_comb begin
    state_next_c = state;
    cnt_next_c   = cnt;
    bit_next_c   = bit_idx;
    shift_next_c = shift;
    tx_next_c    = 1'b1;
    busy_next_c  = 1'b0;

    case (state)
      UTX_IDLE: begin
        if (pop_c) begin
          state_next_c = UTX_START;
          cnt_next_c   = '0;
          shift_next_c = head_c;
        end
      end
      UTX_START: begin
        if (cnt == CNT_LAST) begin
          state_next_c = UTX_DATA;
          cnt_next_c   = '0;
          bit_next_c   = '0;
        end else begin
          cnt_next_c = cnt + CNT_W'(1);
        end
      end
      UTX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next_c   = '0;
          shift_next_c = {1'b0, shift[UART_DATA_W-1:1]};
          if (bit_idx == 3'd7) state_next_c = UTX_STOP;
          else                 bit_next_c   = bit_idx + 3'd1;
        end else begin
          cnt_next_c = cnt + CNT_W'(1);
        end
      end
      UTX_STOP: begin
        if (cnt == CNT_LAST) begin
          state_next_c = UTX_IDLE;
          cnt_next_c   = '0;
        end else begin
          cnt_next_c = cnt + CNT_W'(1);
        end
      end
      default: state_next_c = UTX_IDLE;
    endcase

    case (state_next_c)
      UTX_START: tx_next_c = 1'b0;
      UTX_DATA:  tx_next_c = shift_next_c[0];
      default:   tx_next_c = 1'b1;
    endcase
    busy_next_c = (state_next_c != UTX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= UTX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next_c;
      cnt     <= cnt_next_c;
      bit_idx <= bit_next_c;
      shift   <= shift_next_c;
      tx_q    <= tx_next_c;
      busy_q  <= busy_next_c;
    end
  end

  // Sticky overflow: a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                         overflow_q <= 1'b0;
    else if (bus.wr_en && fifo_full) overflow_q <= 1'b1;
    else if (bus.clr_overflow)       overflow_q <= 1'b0;
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.level    = fifo_level;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomized bench for uart_tx_buffered against a queue-and-frame-timer reference model.
module tb_uart_tx_buffered;
  import uart_tx_buffered_pkg::*;

  localparam int unsigned C      = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned FRAME  = 10 * C;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_buffered_if #(.ADDR_W(ADDR_W)) bus();

  uart_tx_buffered #(
    .CLKS_PER_BIT (C),
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: byte queue plus the elapsed time of the frame on the wire.
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_el;
  logic [7:0] m_cur;
  bit         m_ovf;

  int checks   = 0;
  int failures = 0;

  int         frames_seen = 0;
  int         busy_cycles = 0;
  int         max_level   = 0;
  bit         prev_busy   = 1'b0;
  int         rx_cnt      = 0;
  logic [7:0] rx_sh       = 8'h00;
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int pos;
    if (!m_active) return 1'b1;
    pos = m_el / C;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_cur[pos-1];
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic c);
    bit full_pre;
    bit pop;
    rst              = r;
    bus.wr_en        = w;
    bus.wr_data      = d;
    bus.clr_overflow = c;

    if (r) begin
      m_q.delete();
      m_active = 1'b0;
      m_el     = 0;
      m_ovf    = 1'b0;
    end else begin
      full_pre = (m_q.size() == DEPTH);
      pop      = !m_active && (m_q.size() != 0);
      if (m_active) begin
        m_el++;
        if (m_el == FRAME) m_active = 1'b0;
      end else if (pop) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_el     = 0;
      end
      if (w && !full_pre) m_q.push_back(d);
      if (w && full_pre) m_ovf = 1'b1;
      else if (c)        m_ovf = 1'b0;
    end

    @(posedge clk);
    #1;
    check("tx",       32'(bus.tx),       32'(exp_tx()));
    check("busy",     32'(bus.busy),     32'(m_active));
    check("level",    32'(bus.level),    32'(m_q.size()));
    check("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
    check("empty",    32'(bus.empty),    32'(m_q.size() == 0));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));

    // Independent line receiver, framed by busy, sampling mid-bit.
    if (bus.busy === 1'b1) begin
      busy_cycles++;
      if (!prev_busy) frames_seen++;
      if ((rx_cnt % C) == C / 2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
        rx_sh = {bus.tx, rx_sh[7:1]};
      if (rx_cnt == 9 * C + C / 2 && bus.tx === 1'b1) rx_q.push_back(rx_sh);
      rx_cnt++;
    end else begin
      rx_cnt = 0;
    end
    prev_busy = (bus.busy === 1'b1);
    if (int'(bus.level) > max_level) max_level = int'(bus.level);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((m_active || m_q.size() != 0) && i < budget) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      i++;
    end
    check("drain_timeout", 32'(i < budget), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_bytes[$];
    logic [7:0] abc[3];
    int         f0;
    int         i;
    abc[0] = 8'h41; abc[1] = 8'h42; abc[2] = 8'h43;

    rst              = 1'b1;
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.clr_overflow = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    idle(2);

    // 1: single byte 0x55, level and busy duration.
    busy_cycles = 0;
    rx_q.delete();
    step(1'b0, 1'b1, 8'h55, 1'b0);
    check("t1_level_n", 32'(bus.level), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("t1_level_n1", 32'(bus.level), 32'd0);
    check("t1_tx_start", 32'(bus.tx), 32'd0);
    wait_drain(200);
    idle(2);
    check("t1_busy_cycles", 32'(busy_cycles), 32'd40);
    check("t1_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) check("t1_rx_byte", 32'(rx_q[0]), 32'h55);

    // 2: 'A','B','C' pushed on consecutive cycles.
    rx_q.delete();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, abc[k], 1'b0);
    wait_drain(500);
    idle(2);
    check("t2_rx_count", 32'(rx_q.size()), 32'd3);
    for (int k = 0; k < 3 && k < rx_q.size(); k++) check("t2_rx_byte", 32'(rx_q[k]), 32'(abc[k]));

    // 3: six back-to-back pushes while idle; the sixth is dropped.
    f0 = frames_seen;
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_level", 32'(bus.level), 32'd4);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    wait_drain(1000);
    idle(2);
    check("t3_frames", 32'(frames_seen - f0), 32'd5);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("t3_ovf_clr", 32'(bus.overflow), 32'd0);

    // 4: push while full on the same edge as a pop.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    i = 0;
    while (!(!m_active && m_q.size() != 0) && i < 200) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      i++;
    end
    check("t4_wait_timeout", 32'(i < 200), 32'd1);
    check("t4_full_pre", 32'(bus.full), 32'd1);
    step(1'b0, 1'b1, 8'hEE, 1'b0);
    check("t4_level", 32'(bus.level), 32'd3);
    check("t4_overflow", 32'(bus.overflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("t4_ovf_clr", 32'(bus.overflow), 32'd0);
    wait_drain(1000);
    idle(2);

    // 5: reset during data bit 3 with two bytes queued.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    i = 0;
    while (!(m_active && m_el == 4 * C + 1) && i < 200) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      i++;
    end
    check("t5_wait_timeout", 32'(i < 200), 32'd1);
    check("t5_level_pre", 32'(bus.level), 32'd2);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("t5_tx", 32'(bus.tx), 32'd1);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_level", 32'(bus.level), 32'd0);
    check("t5_empty", 32'(bus.empty), 32'd1);
    f0 = frames_seen;
    idle(100);
    check("t5_no_frames", 32'(frames_seen - f0), 32'd0);

    // 6: ten random bytes spaced one frame apart, across pointer wrap.
    rx_q.delete();
    exp_bytes.delete();
    max_level = 0;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_bytes.push_back(b);
      step(1'b0, 1'b1, b, 1'b0);
      idle(FRAME + 1);
    end
    wait_drain(200);
    idle(2);
    check("t6_max_level", 32'(max_level), 32'd1);
    check("t6_overflow", 32'(bus.overflow), 32'd0);
    check("t6_rx_count", 32'(rx_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < rx_q.size(); k++) check("t6_rx_byte", 32'(rx_q[k]), 32'(exp_bytes[k]));

    // Random traffic with occasional overflow clears.
    for (int k = 0; k < 800; k++)
      step(1'b0, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
    wait_drain(2000);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
